// File: rtl/xphy_int_mc.sv
`default_nettype none
// ============================================================================
// Module  : xphy_int_mc
// Brief   : Multi-channel 10GBASE-R PHY glue: bring-up sequencer, link debounce
//           and idle-forcing XGMII pipelines, one independent set per channel.
// Revision: 1.0
// ============================================================================
module xphy_int_mc #(
    parameter int         C_NUM_CH         = 1,
    parameter logic [4:0] C_MDIO_ADDR_BASE = 5'h0,
    parameter int         C_PIPE           = 1,
    parameter int         C_DEBOUNCE       = 16,
    parameter int         C_GT_PULSE       = 8,
    parameter int         C_DONE_TIMEOUT   = 1024,
    parameter int         C_MAX_RETRY      = 3
) (
    input  logic                     clk156,
    input  logic                     reset,
    input  logic [C_NUM_CH-1:0]      i_chan_restart,
    input  logic [C_NUM_CH-1:0]      i_tx_resetdone,
    input  logic [C_NUM_CH-1:0]      i_rx_resetdone,
    input  logic [C_NUM_CH-1:0]      i_signal_detect,
    input  logic [C_NUM_CH-1:0]      i_tx_fault,
    input  logic [8*C_NUM_CH-1:0]    i_core_status,
    input  logic [64*C_NUM_CH-1:0]   i_xgmii_txd,
    input  logic [8*C_NUM_CH-1:0]    i_xgmii_txc,
    output logic [64*C_NUM_CH-1:0]   o_xgmii_txd_int,
    output logic [8*C_NUM_CH-1:0]    o_xgmii_txc_int,
    input  logic [64*C_NUM_CH-1:0]   i_xgmii_rxd_int,
    input  logic [8*C_NUM_CH-1:0]    i_xgmii_rxc_int,
    output logic [64*C_NUM_CH-1:0]   o_xgmii_rxd,
    output logic [8*C_NUM_CH-1:0]    o_xgmii_rxc,
    output logic [C_NUM_CH-1:0]      o_gt_reset,
    output logic [C_NUM_CH-1:0]      o_core_reset,
    output logic [C_NUM_CH-1:0]      o_axis_aresetn,
    output logic [C_NUM_CH-1:0]      o_link_up,
    output logic [C_NUM_CH-1:0]      o_chan_fail,
    output logic [3*C_NUM_CH-1:0]    o_chan_state,
    output logic [5*C_NUM_CH-1:0]    o_prtad
);

    typedef enum logic [2:0] {
        ST_GTRST = 3'd0,
        ST_WAIT  = 3'd1,
        ST_QUAL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    localparam int CNT_MAX = (C_DONE_TIMEOUT > C_GT_PULSE) ? C_DONE_TIMEOUT : C_GT_PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(C_DEBOUNCE + 1);
    localparam int RTY_W   = $clog2(C_MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] C_PULSE_LAST   = CNT_W'(C_GT_PULSE - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(C_DONE_TIMEOUT - 1);
    localparam logic [DB_W-1:0]  C_DB_LAST      = DB_W'(C_DEBOUNCE - 1);
    localparam logic [RTY_W-1:0] C_RETRY_LIMIT  = RTY_W'(C_MAX_RETRY);
    localparam logic [71:0]      C_IDLE_WORD    = {8'hFF, 64'h0707070707070707};

    // Only the block-lock bit of each status byte is consumed.
    logic w_unused_status;
    assign w_unused_status = ^i_core_status;

    for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_ch
        (* async_reg = "true" *) logic [3:0] r_meta;
        (* async_reg = "true" *) logic [3:0] r_sync;
        logic              w_rd_ok;
        logic              w_raw_ok;
        logic              r_ok;
        logic [DB_W-1:0]   r_db_cnt;
        state_t            r_state;
        state_t            w_nxt_state;
        logic [CNT_W-1:0]  r_cnt;
        logic [CNT_W-1:0]  w_nxt_cnt;
        logic [RTY_W-1:0]  r_retry;
        logic [RTY_W-1:0]  w_nxt_retry;
        logic [RTY_W-1:0]  w_retry_inc;
        logic              r_fail;
        logic              w_nxt_fail;
        logic              r_core_reset;
        logic              r_link_up;
        logic              w_run;
        logic [71:0]       r_tx_pipe [C_PIPE];
        logic [71:0]       r_rx_pipe [C_PIPE];

        // Bit order: {tx_fault, signal_detect, rx_resetdone, tx_resetdone}
        always_ff @(posedge clk156 or posedge reset) begin
            if (reset) begin
                r_meta <= '0;
                r_sync <= '0;
            end else begin
                r_meta <= {i_tx_fault[gi], i_signal_detect[gi],
                           i_rx_resetdone[gi], i_tx_resetdone[gi]};
                r_sync <= r_meta;
            end
        end

        assign w_rd_ok  = r_sync[0] & r_sync[1];
        assign w_raw_ok = r_sync[2] & ~r_sync[3];

        always_ff @(posedge clk156 or posedge reset) begin
            if (reset) begin
                r_ok     <= 1'b0;
                r_db_cnt <= '0;
            end else if (w_raw_ok != r_ok) begin
                if (r_db_cnt == C_DB_LAST) begin
                    r_ok     <= w_raw_ok;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end

        always_ff @(posedge clk156 or posedge reset) begin
            if (reset) begin
                r_state      <= ST_GTRST;
                r_cnt        <= '0;
                r_retry      <= '0;
                r_fail       <= 1'b0;
                r_core_reset <= 1'b1;
                r_link_up    <= 1'b0;
            end else begin
                r_state      <= w_nxt_state;
                r_cnt        <= w_nxt_cnt;
                r_retry      <= w_nxt_retry;
                r_fail       <= w_nxt_fail;
                r_core_reset <= (w_nxt_state != ST_RUN);
                r_link_up    <= (w_nxt_state == ST_RUN) & i_core_status[8*gi];
            end
        end

        assign w_retry_inc = r_retry + 1'b1;

        always_comb begin
            w_nxt_state = r_state;
            w_nxt_cnt   = r_cnt;
            w_nxt_retry = r_retry;
            w_nxt_fail  = r_fail;
            if (i_chan_restart[gi]) begin
                w_nxt_state = ST_GTRST;
                w_nxt_cnt   = '0;
                w_nxt_retry = '0;
                w_nxt_fail  = 1'b0;
            end else begin
                unique case (r_state)
                    ST_GTRST: begin
                        if (r_cnt == C_PULSE_LAST) begin
                            w_nxt_state = ST_WAIT;
                            w_nxt_cnt   = '0;
                        end else begin
                            w_nxt_cnt = r_cnt + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (w_rd_ok) begin
                            w_nxt_state = ST_QUAL;
                            w_nxt_cnt   = '0;
                        end else if (r_cnt == C_TIMEOUT_LAST) begin
                            w_nxt_cnt   = '0;
                            w_nxt_retry = w_retry_inc;
                            if (w_retry_inc == C_RETRY_LIMIT) begin
                                w_nxt_state = ST_FAIL;
                                w_nxt_fail  = 1'b1;
                            end else begin
                                w_nxt_state = ST_GTRST;
                            end
                        end else begin
                            w_nxt_cnt = r_cnt + 1'b1;
                        end
                    end
                    // Losing resetdone outranks qualification: the lane must be re-reset.
                    ST_QUAL: begin
                        if (!w_rd_ok) begin
                            w_nxt_state = ST_GTRST;
                            w_nxt_cnt   = '0;
                        end else if (r_ok) begin
                            w_nxt_state = ST_RUN;
                            w_nxt_retry = '0;
                        end
                    end
                    ST_RUN: begin
                        if (!w_rd_ok) begin
                            w_nxt_state = ST_GTRST;
                            w_nxt_cnt   = '0;
                        end else if (!r_ok) begin
                            w_nxt_state = ST_QUAL;
                        end
                    end
                    ST_FAIL: begin
                        w_nxt_fail = 1'b1;
                    end
                    default: begin
                        w_nxt_state = ST_GTRST;
                        w_nxt_cnt   = '0;
                    end
                endcase
            end
        end

        // Idle gate keys off the registered state, adding no logic depth to the FSM.
        assign w_run = (r_state == ST_RUN);

        always_ff @(posedge clk156 or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < C_PIPE; s++) begin
                    r_tx_pipe[s] <= C_IDLE_WORD;
                    r_rx_pipe[s] <= C_IDLE_WORD;
                end
            end else begin
                r_tx_pipe[0] <= w_run ? {i_xgmii_txc[8*gi +: 8], i_xgmii_txd[64*gi +: 64]}
                                      : C_IDLE_WORD;
                r_rx_pipe[0] <= w_run ? {i_xgmii_rxc_int[8*gi +: 8], i_xgmii_rxd_int[64*gi +: 64]}
                                      : C_IDLE_WORD;
                for (int s = 1; s < C_PIPE; s++) begin
                    r_tx_pipe[s] <= r_tx_pipe[s-1];
                    r_rx_pipe[s] <= r_rx_pipe[s-1];
                end
            end
        end

        assign o_xgmii_txd_int[64*gi +: 64] = r_tx_pipe[C_PIPE-1][63:0];
        assign o_xgmii_txc_int[8*gi +: 8]   = r_tx_pipe[C_PIPE-1][71:64];
        assign o_xgmii_rxd[64*gi +: 64]     = r_rx_pipe[C_PIPE-1][63:0];
        assign o_xgmii_rxc[8*gi +: 8]       = r_rx_pipe[C_PIPE-1][71:64];

        assign o_gt_reset[gi]          = (r_state == ST_GTRST);
        assign o_core_reset[gi]        = r_core_reset;
        assign o_axis_aresetn[gi]      = ~r_core_reset;
        assign o_link_up[gi]           = r_link_up;
        assign o_chan_fail[gi]         = r_fail;
        assign o_chan_state[3*gi +: 3] = r_state;
        assign o_prtad[5*gi +: 5]      = C_MDIO_ADDR_BASE + 5'(gi);
    end

endmodule
`default_nettype wire

// File: tb/tb_xphy_int_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_xphy_int_mc
// Brief   : Directed + randomized bench for xphy_int_mc against a timing-rule model.
// Revision: 1.0
// ============================================================================
module tb_xphy_int_mc;

    localparam int         NCH  = 2;
    localparam logic [4:0] BASE = 5'h1F;
    localparam int         PIPE = 3;
    localparam int         DEB  = 16;
    localparam int         GTP  = 8;
    localparam int         TO   = 64;
    localparam int         MAXR = 3;
    localparam logic [71:0] IDLE = {8'hFF, 64'h0707070707070707};

    logic               clk156 = 1'b0;
    logic               reset  = 1'b1;
    logic [NCH-1:0]     restart = '0;
    logic [NCH-1:0]     txrd = '0;
    logic [NCH-1:0]     rxrd = '0;
    logic [NCH-1:0]     sd = '1;
    logic [NCH-1:0]     fault = 2'b10;
    logic [8*NCH-1:0]   cs = '0;
    logic [64*NCH-1:0]  txd = '0;
    logic [8*NCH-1:0]   txc = '0;
    logic [64*NCH-1:0]  rxd_int = '0;
    logic [8*NCH-1:0]   rxc_int = '0;
    logic [64*NCH-1:0]  txd_int, rxd;
    logic [8*NCH-1:0]   txc_int, rxc;
    logic [NCH-1:0]     gt_reset, core_reset, aresetn, link_up, chan_fail;
    logic [3*NCH-1:0]   chan_state;
    logic [5*NCH-1:0]   prtad;

    int n_checks = 0;
    int n_errors = 0;

    xphy_int_mc #(
        .C_NUM_CH(NCH), .C_MDIO_ADDR_BASE(BASE), .C_PIPE(PIPE), .C_DEBOUNCE(DEB),
        .C_GT_PULSE(GTP), .C_DONE_TIMEOUT(TO), .C_MAX_RETRY(MAXR)
    ) dut (
        .clk156(clk156), .reset(reset), .i_chan_restart(restart),
        .i_tx_resetdone(txrd), .i_rx_resetdone(rxrd),
        .i_signal_detect(sd), .i_tx_fault(fault), .i_core_status(cs),
        .i_xgmii_txd(txd), .i_xgmii_txc(txc),
        .o_xgmii_txd_int(txd_int), .o_xgmii_txc_int(txc_int),
        .i_xgmii_rxd_int(rxd_int), .i_xgmii_rxc_int(rxc_int),
        .o_xgmii_rxd(rxd), .o_xgmii_rxc(rxc),
        .o_gt_reset(gt_reset), .o_core_reset(core_reset), .o_axis_aresetn(aresetn),
        .o_link_up(link_up), .o_chan_fail(chan_fail), .o_chan_state(chan_state),
        .o_prtad(prtad)
    );

    always #5 clk156 = ~clk156;

    // Model: inputs seen through a two-edge delay, then timing rules per channel.
    bit [3:0]    m_meta [NCH];
    bit [3:0]    m_sync [NCH];
    int          m_st [NCH];
    int          m_cnt [NCH];
    int          m_retry [NCH];
    int          m_db [NCH];
    bit          m_ok [NCH];
    bit          m_fail [NCH];
    bit          m_core_reset [NCH];
    bit          m_link [NCH];
    logic [71:0] m_txh [NCH][8];
    logic [71:0] m_rxh [NCH][8];
    int          m_cyc;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_meta[c] = '0; m_sync[c] = '0; m_st[c] = 0; m_cnt[c] = 0; m_retry[c] = 0;
            m_db[c] = 0; m_ok[c] = 1'b0; m_fail[c] = 1'b0; m_core_reset[c] = 1'b1; m_link[c] = 1'b0;
        end
        m_cyc = 0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit rd, raw;
            int nst;
            rd  = m_sync[c][0] & m_sync[c][1];
            raw = m_sync[c][2] & ~m_sync[c][3];
            m_txh[c][m_cyc % 8] = (m_st[c] == 3) ? {txc[8*c +: 8], txd[64*c +: 64]} : IDLE;
            m_rxh[c][m_cyc % 8] = (m_st[c] == 3) ? {rxc_int[8*c +: 8], rxd_int[64*c +: 64]} : IDLE;
            nst = m_st[c];
            if (restart[c]) begin
                nst = 0; m_retry[c] = 0; m_fail[c] = 1'b0;
            end else begin
                case (m_st[c])
                    0: if (m_cnt[c] == GTP - 1) nst = 1;
                    1: if (rd) nst = 2;
                       else if (m_cnt[c] == TO - 1) begin
                           m_retry[c]++;
                           nst = (m_retry[c] == MAXR) ? 4 : 0;
                       end
                    2: nst = !rd ? 0 : (m_ok[c] ? 3 : 2);
                    3: nst = !rd ? 0 : (m_ok[c] ? 3 : 2);
                    default: nst = 4;
                endcase
                if (nst == 3 && m_st[c] != 3) m_retry[c] = 0;
                if (nst == 4) m_fail[c] = 1'b1;
            end
            m_cnt[c] = (restart[c] || nst != m_st[c]) ? 0 : m_cnt[c] + 1;
            if (raw != m_ok[c]) begin
                m_db[c]++;
                if (m_db[c] == DEB) begin m_ok[c] = raw; m_db[c] = 0; end
            end else begin
                m_db[c] = 0;
            end
            m_core_reset[c] = (nst != 3);
            m_link[c]       = (nst == 3) && cs[8*c];
            m_st[c]         = nst;
            m_sync[c]       = m_meta[c];
            m_meta[c]       = {fault[c], sd[c], rxrd[c], txrd[c]};
        end
        m_cyc++;
    endtask

    task automatic check(input string tag, input int ch, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s ch%0d: observed %h expected %h", tag, ch, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            logic [71:0] etx, erx;
            etx = (m_cyc >= PIPE) ? m_txh[c][(m_cyc - PIPE) % 8] : IDLE;
            erx = (m_cyc >= PIPE) ? m_rxh[c][(m_cyc - PIPE) % 8] : IDLE;
            check("state",      c, 72'(chan_state[3*c +: 3]), 72'(m_st[c]));
            check("gt_reset",   c, 72'(gt_reset[c]),   72'(m_st[c] == 0));
            check("core_reset", c, 72'(core_reset[c]), 72'(m_core_reset[c]));
            check("aresetn",    c, 72'(aresetn[c]),    72'(!m_core_reset[c]));
            check("link_up",    c, 72'(link_up[c]),    72'(m_link[c]));
            check("chan_fail",  c, 72'(chan_fail[c]),  72'(m_fail[c]));
            check("tx_path",    c, {txc_int[8*c +: 8], txd_int[64*c +: 64]}, etx);
            check("rx_path",    c, {rxc[8*c +: 8], rxd[64*c +: 64]}, erx);
            check("prtad",      c, 72'(prtad[5*c +: 5]), 72'(5'(BASE + 5'(c))));
        end
    endtask

    task automatic randomize_data();
        txd     = {$urandom, $urandom, $urandom, $urandom};
        rxd_int = {$urandom, $urandom, $urandom, $urandom};
        txc     = 16'($urandom);
        rxc_int = 16'($urandom);
        cs      = 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk156);
        if (!reset) model_step();
        @(negedge clk156);
        check_all();
        randomize_data();
    endtask

    initial begin
        int pulses;
        logic prev_gt;
        model_reset();

        // Reset state; ch0 sees optics OK, ch1 sees a TX fault.
        repeat (3) tick();
        reset = 1'b0;

        // resetdone rises at cycle 20; ch0 walks GTRST, WAIT, QUAL, RUN.
        repeat (20) tick();
        txrd = 2'b11; rxrd = 2'b11;
        repeat (40) tick();
        check("ch0_in_run", 0, 72'(chan_state[2:0]), 72'(3));
        check("ch1_in_qual", 1, 72'(chan_state[5:3]), 72'(2));

        // A 15-cycle signal_detect glitch is absorbed; a 25-cycle loss drops to QUAL.
        sd[0] = 1'b0; repeat (15) tick(); sd[0] = 1'b1;
        repeat (20) tick();
        check("glitch_keeps_run", 0, 72'(chan_state[2:0]), 72'(3));
        sd[0] = 1'b0; repeat (25) tick();
        check("loss_to_qual", 0, 72'(chan_state[2:0]), 72'(2));
        check("loss_core_reset", 0, 72'(core_reset[0]), 72'(1));
        sd[0] = 1'b1; repeat (25) tick();
        check("back_to_run", 0, 72'(chan_state[2:0]), 72'(3));

        // ch1 loses resetdone: three timed-out GT resets then sticky FAIL.
        txrd[1] = 1'b0;
        pulses = 0; prev_gt = gt_reset[1];
        repeat (3 * (GTP + TO) + 20) begin
            tick();
            if (gt_reset[1] && !prev_gt) pulses++;
            prev_gt = gt_reset[1];
        end
        check("retry_pulses", 1, 72'(pulses), 72'(MAXR));
        check("fail_state", 1, 72'(chan_state[5:3]), 72'(4));
        check("fail_flag", 1, 72'(chan_fail[1]), 72'(1));
        restart[1] = 1'b1; tick(); restart[1] = 1'b0;
        check("restart_clears", 1, 72'(chan_fail[1]), 72'(0));
        check("restart_pulse", 1, 72'(gt_reset[1]), 72'(1));
        txrd[1] = 1'b1;
        repeat (20) tick();

        // Randomized disturbances on every conditioned input.
        repeat (800) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 24) == 0) sd[c] = ~sd[c];
                if ($urandom_range(0, 99) == 0) fault[c] = ~fault[c];
                if ($urandom_range(0, 149) == 0) txrd[c] = ~txrd[c];
                if ($urandom_range(0, 149) == 0) rxrd[c] = ~rxrd[c];
                restart[c] = ($urandom_range(0, 199) == 0);
            end
            tick();
        end

        // Settle ch0 into RUN, then assert reset between clock edges.
        restart = '0; sd = 2'b11; fault = 2'b00; txrd = 2'b11; rxrd = 2'b11;
        repeat (3 * (GTP + TO) + 60) tick();
        check("pre_reset_run", 0, 72'(chan_state[2:0]), 72'(3));
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("restart_gtrst", 0, 72'(chan_state[2:0]), 72'(0));
        repeat (60) tick();
        check("rerun", 0, 72'(chan_state[2:0]), 72'(3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xphy_int_mc.md
Name: xphy_int_mc

Overview:
Multi-channel successor to the single-lane 10GBASE-R PHY glue. For each of C_NUM_CH channels it provides:
- a reset/bring-up sequencer with resetdone timeout and bounded GT-reset retry;
- debounced link qualification (signal_detect, tx_fault);
- idle-forcing, parametrised-depth XGMII pipelines between MAC and PHY core.

Everything runs in the clk156 domain. It sits between the MAC AXI wrappers and the per-lane PHY cores/transceivers.

Parameters:
C_NUM_CH, 1, channel count (1..4); all per-channel ports are flattened, channel i at slice i.
C_MDIO_ADDR_BASE, 5'h0, channel i prtad = C_MDIO_ADDR_BASE + i (5-bit wrap).
C_PIPE, 1, XGMII register stages per direction (1..3).
C_DEBOUNCE, 16, consecutive stable cycles before the qualified link-OK changes.
C_GT_PULSE, 8, gt_reset assertion length in cycles.
C_DONE_TIMEOUT, 1024, cycles allowed in WAIT before a retry.
C_MAX_RETRY, 3, GT resets attempted before FAIL.

Ports:
clk156  in  1  core clock, 156.25 MHz
reset  in  1  asynchronous, active-high
chan_restart  in  C_NUM_CH  per-channel one-cycle restart request
tx_resetdone  in  C_NUM_CH  async transceiver TX reset done
rx_resetdone  in  C_NUM_CH  async transceiver RX reset done
signal_detect  in  C_NUM_CH  async optics signal detect
tx_fault  in  C_NUM_CH  async optics TX fault
core_status  in  8*C_NUM_CH  PHY core status; bit 0 of each byte is PCS block lock
xgmii_txd / xgmii_txc  in  64*N / 8*N  from MAC
xgmii_txd_int / xgmii_txc_int  out  64*N / 8*N  to PHY core
xgmii_rxd_int / xgmii_rxc_int  in  64*N / 8*N  from PHY core
xgmii_rxd / xgmii_rxc  out  64*N / 8*N  to MAC
gt_reset  out  C_NUM_CH  transceiver reset
core_reset  out  C_NUM_CH  PHY core reset
axis_aresetn  out  C_NUM_CH  MAC AXI reset, active-low
link_up  out  C_NUM_CH  registered link indication
chan_fail  out  C_NUM_CH  sticky bring-up failure
chan_state  out  3*C_NUM_CH  FSM state encoding
prtad  out  5*C_NUM_CH  MDIO port addresses (constant)

Behaviour:
Input conditioning
- resetdone, signal_detect and tx_fault each pass a 2-flop synchroniser (async_reg); synchroniser reset value 0.
- raw_ok = sd_sync & ~fault_sync.
- Debouncer: qualified ok starts at 0. It takes the value of raw_ok only after raw_ok has differed from it for C_DEBOUNCE consecutive cycles. Any return to agreement clears the counter.

Sequencer FSM, per channel. Encoding: GTRST=0, WAIT=1, QUAL=2, RUN=3, FAIL=4. Reset state is GTRST with counters 0.
- GTRST: gt_reset=1 for C_GT_PULSE cycles, then WAIT.
- WAIT: the timer counts. If both resetdone_sync are 1, go to QUAL. Else, when the timer reaches C_DONE_TIMEOUT-1, increment retry; if the new retry equals C_MAX_RETRY go to FAIL, otherwise go to GTRST.
- QUAL: go to RUN when qualified ok=1. No timeout. If either resetdone_sync drops, go to GTRST.
- RUN: retry cleared on entry. If either resetdone_sync drops, go to GTRST. Else if qualified ok=0, go to QUAL.
- FAIL: chan_fail=1 (sticky). Leaves only on reset or chan_restart.
- chan_restart in any state: next state GTRST; retry, timer and chan_fail cleared. chan_restart has priority over every other transition.

Outputs
- core_reset = (state != RUN), registered.
- axis_aresetn = ~core_reset.
- link_up is registered: (state==RUN) & core_status[8i].
- Reset values: gt_reset=1, core_reset=1, axis_aresetn=0, link_up=0, chan_fail=0, chan_state=0.

Datapath
- TX: the input stage captures (state==RUN) ? MAC data : idle, where idle is txd=64'h0707070707070707 and txc=8'hFF. It then passes C_PIPE-1 further stages, so total latency is C_PIPE cycles.
- RX: identical, sourced from *_int, with the same idle substitution when not in RUN.
- All pipeline registers reset to idle.
- The idle gate uses the registered state, so the first real word reaches the output C_PIPE cycles after the cycle in which chan_state==3 is first visible.

Channels are fully independent: no shared counters.

Test Plan:
1. Reset release; resetdone=1 at cycle 20; sd=1, fault=0 from cycle 0 (C_DEBOUNCE=16) -> state GTRST for 8 cycles, then WAIT, QUAL, RUN. core_reset deasserts only in RUN, and not before the debounce completes (16 cycles after the synchroniser).
2. resetdone held 0 (C_DONE_TIMEOUT=64, C_MAX_RETRY=3) -> exactly 3 gt_reset pulses of 8 cycles, then chan_fail=1 and state=4. A chan_restart pulse clears chan_fail and produces a new gt_reset pulse.
3. In RUN, sd glitches low for 15 cycles -> stays RUN. A low of 17+ cycles -> QUAL; core_reset=1; xgmii_txd_int=0707...07 and txc=FF after C_PIPE cycles.
4. C_PIPE=3, MAC drives txd=0x0123456789ABCDEF, txc=0x00 in RUN -> appears on xgmii_txd_int exactly 3 cycles later. RX path gives the same 3-cycle latency.
5. C_NUM_CH=2, tx_fault on ch1 only -> ch0 reaches RUN with link_up[0]=core_status[0]; ch1 sits in QUAL; prtad = {5'h1,5'h0}.
6. Assert reset mid-RUN -> all outputs return to their reset values immediately (asynchronously); the sequence restarts from GTRST.
